// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with a single outstanding memory request and a
// small in-order instruction buffer; redirect flushes and drains stale responses.
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pcplus4_out,
  output logic        illegal_op
);

  localparam int PTR_W = (BUF_DEPTH == 4) ? 2 : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(BUF_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]       state, state_nx;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_addr;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count, count_nx;
  logic [31:0]      buf_addr [BUF_DEPTH];
  logic [31:0]      buf_data [BUF_DEPTH];
  logic             grant, push, pop, legal;

  // A redirect withdraws an ungranted request in the same cycle.
  assign imem_req    = (state == ST_REQ) & ~redirect;
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req & imem_gnt;
  assign push        = (state == ST_WAIT) & imem_rvalid & ~redirect;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & ~stall & ~redirect;
  assign count_nx    = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

  assign instr       = instr_valid ? buf_data[rd_ptr] : 32'h0;
  assign pc_out      = instr_valid ? buf_addr[rd_ptr] : 32'h0;
  assign pcplus4_out = instr_valid ? buf_addr[rd_ptr] + 32'd4 : 32'h0;
  assign illegal_op  = instr_valid & ~legal;

  always_comb begin
    legal = 1'b0;
    case (instr[6:0])
      7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011,
      7'b0110111, 7'b0010111, 7'b1100111, 7'b1101111: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (redirect) begin
      // A response still in flight must be swallowed before refetching.
      if (((state == ST_WAIT) || (state == ST_DRAIN)) && !imem_rvalid)
        state_nx = ST_DRAIN;
      else
        state_nx = ST_REQ;
    end else begin
      case (state)
        ST_IDLE:  if (count < FULL_CNT) state_nx = ST_REQ;
        ST_REQ:   if (imem_gnt) state_nx = ST_WAIT;
        ST_WAIT:  if (imem_rvalid) state_nx = (count_nx < FULL_CNT) ? ST_REQ : ST_IDLE;
        ST_DRAIN: if (imem_rvalid) state_nx = ST_REQ;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nx;
      if (redirect) begin
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
          req_addr <= fetch_pc;
        end
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= req_addr;
      buf_data[wr_ptr] <= imem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-configurable memory model.
`default_nettype none

module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid, stall, redirect;
  logic [31:0] imem_addr, imem_rdata, redirect_pc;
  logic        instr_valid, illegal_op;
  logic [31:0] instr, pc_out, pcplus4_out;

  logic        req_b, gnt_b, rvalid_b, stall_b, redirect_b;
  logic [31:0] addr_b, rdata_b, redirect_pc_b;
  logic        valid_b, illegal_b;
  logic [31:0] instr_b, pc_b, pcp4_b;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out),
    .pcplus4_out(pcplus4_out), .illegal_op(illegal_op)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req_b), .imem_addr(addr_b), .imem_gnt(gnt_b),
    .imem_rvalid(rvalid_b), .imem_rdata(rdata_b),
    .stall(stall_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
    .instr_valid(valid_b), .instr(instr_b), .pc_out(pc_b),
    .pcplus4_out(pcp4_b), .illegal_op(illegal_b)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [31:0] exp_pc, pend_addr, mem_addr, ovr_data;
  bit          pend, drop_next, mem_busy, ovr_en, granted_b;
  int          mem_lat, mem_cnt, cyc;
  int          first_req_cyc, first_valid_cyc;
  int          g_cnt, grants_b;
  logic [31:0] g_log [3];
  logic [31:0] gb0, gb1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[26:2], 7'h13};
  endfunction

  function automatic bit legal_op(input logic [6:0] op);
    case (op)
      7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h67, 7'h6F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_model(input logic [31:0] rpc);
    exp_q.delete();
    exp_pc = rpc; pend = 0; drop_next = 0; mem_busy = 0;
    imem_rvalid = 0; rvalid_b = 0; granted_b = 0;
    first_req_cyc = -1; first_valid_cyc = -1; g_cnt = 0; grants_b = 0;
    gb0 = 32'hDEAD_BEEF; gb1 = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) g_log[i] = 32'hDEAD_BEEF;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_req"},     imem_req,    0);
    check({pfx, "_valid"},   instr_valid, 0);
    check({pfx, "_illegal"}, illegal_op,  0);
    check({pfx, "_instr"},   instr,       0);
    check({pfx, "_pc"},      pc_out,      0);
    check({pfx, "_pcp4"},    pcplus4_out, 0);
  endtask

  // One clock: compare at the falling edge, update the model, then drive memory.
  task automatic cycle();
    logic [63:0] head;
    bit granted;
    granted = 0;
    @(negedge clk);
    if (rst_n) begin
      check("instr_valid", instr_valid, exp_q.size() != 0);
      if (exp_q.size() != 0 && instr_valid) begin
        head = exp_q[0];
        check("instr",      instr,       head[31:0]);
        check("pc_out",     pc_out,      head[63:32]);
        check("pcplus4",    pcplus4_out, head[63:32] + 32'd4);
        check("illegal_op", illegal_op,  !legal_op(head[6:0]));
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (drop_next) check("drain_req", imem_req, 0);
      if (imem_req) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        check("imem_addr", imem_addr, exp_pc);
      end
      if (exp_q.size() != 0 && !stall && !redirect) void'(exp_q.pop_front());
      if (imem_rvalid) begin
        if (!redirect && !drop_next) exp_q.push_back({pend_addr, imem_rdata});
        drop_next = 0;
        pend = 0;
      end
      if (redirect) begin
        exp_q.delete();
        if (pend) drop_next = 1;
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      granted = imem_req && imem_gnt;
      if (granted) begin
        check("one_outstanding", pend, 0);
        if (g_cnt < 3) g_log[g_cnt] = imem_addr;
        g_cnt++;
        pend = 1; pend_addr = exp_pc; exp_pc = exp_pc + 32'd4;
        mem_busy = 1; mem_cnt = mem_lat; mem_addr = imem_addr;
      end
      granted_b = req_b && gnt_b;
      if (granted_b) begin
        if (grants_b == 0) gb0 = addr_b;
        if (grants_b == 1) gb1 = addr_b;
        grants_b++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rvalid = 0;
    if (mem_busy && rst_n) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1;
        imem_rdata  = ovr_en ? ovr_data : mem_word(mem_addr);
        mem_busy    = 0;
      end
    end
    rvalid_b  = granted_b && rst_n;
    rdata_b   = 32'h0000_0013;
    granted_b = 0;
  endtask

  task automatic run_to_wait();
    int n;
    n = 0;
    while (!(pend && !imem_rvalid) && n < 30) begin
      cycle();
      n++;
    end
    check("reach_wait", pend && !imem_rvalid, 1);
  endtask

  task automatic run_to_head(input logic [31:0] data);
    int n;
    n = 0;
    while (!(instr_valid && instr == data) && n < 30) begin
      cycle();
      n++;
    end
    check("head_seen", instr_valid && instr == data, 1);
  endtask

  logic [31:0] p1;
  int n;

  initial begin
    rst_n = 0; imem_gnt = 1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_rdata = 0; gnt_b = 1; stall_b = 1; redirect_b = 0; redirect_pc_b = 0;
    rdata_b = 0; mem_lat = 1; ovr_en = 0; ovr_data = 0; cyc = 0; mem_cnt = 0;
    mem_addr = 0; pend_addr = 0;
    clear_model(32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    check("reset_b_req", req_b, 0);

    // Streaming fetch with gnt held and single-cycle response latency.
    @(posedge clk); #1;
    rst_n = 1; cyc = 0;
    repeat (14) cycle();
    check("first_req_cyc",   first_req_cyc,   1);
    check("first_valid_cyc", first_valid_cyc, 3);
    check("fetch_addr0", g_log[0], 32'h0);
    check("fetch_addr1", g_log[1], 32'h4);
    check("fetch_addr2", g_log[2], 32'h8);

    // Second instance: wrap at the top of the address space, deeper buffer.
    check("b_first_addr",  gb0,      32'hFFFF_FFFC);
    check("b_second_addr", gb1,      32'h0);
    check("b_grants",      grants_b, 4);
    check("b_idle_req",    req_b,    0);
    check("b_valid",       valid_b,  1);
    check("b_pc_out",      pc_b,     32'hFFFF_FFFC);
    check("b_pcplus4",     pcp4_b,   32'h0);

    // Stall: buffer fills, fetch idles, then drains back to back.
    stall = 1;
    repeat (10) cycle();
    check("stall_req_idle", imem_req,    0);
    check("stall_valid",    instr_valid, 1);
    p1 = pc_out;
    stall = 0;
    cycle();
    check("stall_pop2_valid", instr_valid, 1);
    check("stall_pop2_pc",    pc_out,      p1 + 32'd4);
    repeat (4) cycle();

    // Redirect while a response is outstanding.
    mem_lat = 3;
    run_to_wait();
    ovr_en = 1; ovr_data = 32'h0000_0013;
    redirect = 1; redirect_pc = 32'h0000_0103;
    cycle();
    redirect = 0;
    check("redir_flush_valid", instr_valid, 0);
    check("redir_drain_req",   imem_req,    0);
    n = 0;
    while (!imem_req && n < 20) begin
      cycle();
      n++;
    end
    check("redir_next_addr", imem_addr, 32'h0000_0100);
    ovr_en = 0; mem_lat = 1;
    repeat (6) cycle();

    // Illegal and legal opcodes at the buffer head.
    ovr_en = 1; ovr_data = 32'h0000_007F;
    run_to_head(32'h0000_007F);
    check("illegal_7f", illegal_op, 1);
    ovr_data = 32'h0000_0033;
    run_to_head(32'h0000_0033);
    check("legal_33", illegal_op, 0);
    ovr_en = 0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      imem_gnt    = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      mem_lat     = $urandom_range(1, 3);
      ovr_en      = ($urandom_range(0, 3) == 0);
      ovr_data    = $urandom;
      cycle();
    end
    imem_gnt = 1; stall = 0; redirect = 0; ovr_en = 0;
    repeat (8) cycle();

    // Asynchronous reset in the middle of a WAIT cycle.
    mem_lat = 3;
    run_to_wait();
    #2;
    rst_n = 0;
    #1;
    check_zero("async_rst");
    check("async_rst_addr", imem_addr, 32'h0);
    clear_model(32'h0);
    mem_lat = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1; cyc = 0;
    n = 0;
    while (!imem_req && n < 10) begin
      cycle();
      n++;
    end
    check("post_rst_addr", imem_addr, 32'h0);
    repeat (10) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
